// File: rtl/ctrl_pkg.sv
// ==========================================================================
// ctrl_pkg : shared encodings and control bundle for pipe_controller | Rev 1.0
// ==========================================================================
`default_nettype none

package ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLL  = 4'd6;
   localparam logic [3:0] ALU_SRL  = 4'd7;
   localparam logic [3:0] ALU_SRA  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_MD  = 2'b11;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Store/Load size codes are funct3 (store uses the low two bits)
   localparam logic [1:0] ST_B  = 2'b00;
   localparam logic [1:0] ST_H  = 2'b01;
   localparam logic [1:0] ST_W  = 2'b10;
   localparam logic [2:0] LD_B  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_W  = 3'b010;
   localparam logic [2:0] LD_BU = 3'b100;
   localparam logic [2:0] LD_HU = 3'b101;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic       jalr;
      logic       alu_src;
      logic       op5;
      logic [1:0] result_src;
      logic [1:0] store;
      logic [2:0] load;
      logic [3:0] alu_control;
      logic       md_valid;
      logic [2:0] md_op;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ==========================================================================
// ctrl_decode : combinational RV32I/M Decode-stage control decoder | Rev 1.0
// ==========================================================================
`default_nettype none

module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       valid,
   output ctrl_t      ctrl,
   output logic [1:0] imm_src,
   output logic       illegal,
   output logic       is_md
);

   ctrl_t      w_base;
   logic [1:0] w_alu_op;
   logic [3:0] w_alu_ctl;
   logic       w_known;
   logic       w_md_enc;

   assign w_md_enc = (op == OP_RTYPE) && (funct7 == F7_MULDIV);
   assign illegal  = valid && (!w_known || (w_md_enc && !ENABLE_M));
   assign is_md    = valid && w_md_enc && ENABLE_M;

   always_comb begin
      w_base   = CTRL_BUBBLE;
      w_alu_op = ALUOP_ADD;
      w_known  = 1'b1;
      imm_src  = IMM_I;
      case (op)
         OP_LOAD: begin
            w_base.reg_write  = 1'b1;
            w_base.alu_src    = 1'b1;
            w_base.result_src = RES_MEM;
            w_base.load       = funct3;
         end
         OP_STORE: begin
            w_base.mem_write = 1'b1;
            w_base.alu_src   = 1'b1;
            w_base.store     = funct3[1:0];
            imm_src          = IMM_S;
         end
         OP_RTYPE: begin
            w_base.reg_write = 1'b1;
            w_alu_op         = ALUOP_FUNC;
         end
         OP_ITYPE: begin
            w_base.reg_write = 1'b1;
            w_base.alu_src   = 1'b1;
            w_alu_op         = ALUOP_FUNC;
         end
         OP_BRANCH: begin
            w_base.branch = 1'b1;
            w_alu_op      = ALUOP_SUB;
            imm_src       = IMM_B;
         end
         OP_JAL: begin
            w_base.reg_write  = 1'b1;
            w_base.jump       = 1'b1;
            w_base.result_src = RES_PC4;
            imm_src           = IMM_J;
         end
         OP_JALR: begin
            w_base.reg_write  = 1'b1;
            w_base.jalr       = 1'b1;
            w_base.alu_src    = 1'b1;
            w_base.result_src = RES_PC4;
         end
         default: w_known = 1'b0;
      endcase
      w_base.op5 = op[5];
   end

   // SUB needs both op[5] (register form) and funct7[5]; I-type bit 30 is immediate
   always_comb begin
      w_alu_ctl = ALU_ADD;
      case (w_alu_op)
         ALUOP_SUB: w_alu_ctl = ALU_SUB;
         ALUOP_FUNC: begin
            case (funct3)
               3'b000:  w_alu_ctl = (op[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
               3'b001:  w_alu_ctl = ALU_SLL;
               3'b010:  w_alu_ctl = ALU_SLT;
               3'b011:  w_alu_ctl = ALU_SLTU;
               3'b100:  w_alu_ctl = ALU_XOR;
               3'b101:  w_alu_ctl = funct7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  w_alu_ctl = ALU_OR;
               default: w_alu_ctl = ALU_AND;
            endcase
         end
         default: w_alu_ctl = ALU_ADD;
      endcase
   end

   // Illegal is reported on its own port; the bundle stays a pure bubble
   always_comb begin
      ctrl             = w_base;
      ctrl.alu_control = w_alu_ctl;
      if (is_md) begin
         ctrl.alu_control = ALU_ADD;
         ctrl.result_src  = RES_MD;
         ctrl.md_valid    = 1'b1;
         ctrl.md_op       = funct3;
      end
      if (!valid || illegal) begin
         ctrl = CTRL_BUBBLE;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pipe_controller.sv
// ==========================================================================
// pipe_controller : Decode->Execute control registers and MulDiv hold FSM | Rev 1.0
// ==========================================================================
`default_nettype none

module pipe_controller
   import ctrl_pkg::*;
#(
   parameter bit ENABLE_M   = 1'b1,
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 34,
   parameter int CNT_W      = $clog2(64)
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       ValidD,
   input  logic       StallE,
   input  logic       FlushE,
   output logic [1:0] ImmSrcD,
   output logic       MdStallD,
   output logic       RegWriteE,
   output logic       MemWriteE,
   output logic       JumpE,
   output logic       BranchE,
   output logic       JalrE,
   output logic       ALUSrcE,
   output logic       Op5E,
   output logic [1:0] ResultSrcE,
   output logic [1:0] StoreE,
   output logic [2:0] LoadE,
   output logic [3:0] ALUControlE,
   output logic       MdValidE,
   output logic [2:0] MdOpE,
   output logic       MdStartE,
   output logic       IllegalE
);

   localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_CYCLES - 2);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);
   localparam bit               MUL_MULTI = (MUL_CYCLES > 1);
   localparam bit               DIV_MULTI = (DIV_CYCLES > 1);

   ctrl_t            w_dec_ctrl;
   ctrl_t            w_dec_e;
   logic             w_dec_illegal;
   logic             w_dec_is_md;
   ctrl_t            r_ctrl_e;
   logic             r_md_start;
   md_state_t        r_state;
   md_state_t        w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_flush;
   logic             w_load;
   logic             w_multi;
   logic [CNT_W-1:0] w_cnt_load;

   ctrl_decode #(
      .ENABLE_M (ENABLE_M)
   ) u_decode (
      .op      (op),
      .funct3  (funct3),
      .funct7  (funct7),
      .valid   (ValidD),
      .ctrl    (w_dec_ctrl),
      .imm_src (ImmSrcD),
      .illegal (w_dec_illegal),
      .is_md   (w_dec_is_md)
   );

   always_comb begin
      w_dec_e         = w_dec_ctrl;
      w_dec_e.illegal = w_dec_illegal;
   end

   // The busy M op is the oldest instruction, so a flush while busy is dropped
   assign w_flush    = FlushE && !MdStallD;
   assign w_load     = !w_flush && !StallE && !MdStallD;
   assign w_multi    = funct3[2] ? DIV_MULTI : MUL_MULTI;
   assign w_cnt_load = funct3[2] ? DIV_LOAD : MUL_LOAD;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_ctrl_e   <= CTRL_BUBBLE;
         r_md_start <= 1'b0;
      end else begin
         r_md_start <= w_load && w_dec_is_md;
         if (w_flush) begin
            r_ctrl_e <= CTRL_BUBBLE;
         end else if (w_load) begin
            r_ctrl_e <= w_dec_e;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Counter holds remaining busy cycles minus one; exit on the zero cycle
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_load && w_dec_is_md && w_multi) begin
               w_state_next = MD_BUSY;
               w_cnt_next   = w_cnt_load;
            end
         end
         MD_BUSY: begin
            if (r_cnt == '0) begin
               w_state_next = IDLE;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      MdStallD = (r_state == MD_BUSY);
   end

   assign RegWriteE   = r_ctrl_e.reg_write;
   assign MemWriteE   = r_ctrl_e.mem_write;
   assign JumpE       = r_ctrl_e.jump;
   assign BranchE     = r_ctrl_e.branch;
   assign JalrE       = r_ctrl_e.jalr;
   assign ALUSrcE     = r_ctrl_e.alu_src;
   assign Op5E        = r_ctrl_e.op5;
   assign ResultSrcE  = r_ctrl_e.result_src;
   assign StoreE      = r_ctrl_e.store;
   assign LoadE       = r_ctrl_e.load;
   assign ALUControlE = r_ctrl_e.alu_control;
   assign MdValidE    = r_ctrl_e.md_valid;
   assign MdOpE       = r_ctrl_e.md_op;
   assign IllegalE    = r_ctrl_e.illegal;
   assign MdStartE    = r_md_start;

endmodule

`default_nettype wire

// File: tb/tb_pipe_controller.sv
// ==========================================================================
// tb_pipe_controller : self-checking bench for pipe_controller | Rev 1.0
// ==========================================================================
`default_nettype none

module tb_pipe_controller;

   localparam int MUL_L = 1;
   localparam int DIV_L = 34;

   localparam logic [6:0] T_LD = 7'b0000011, T_ST = 7'b0100011, T_R = 7'b0110011;
   localparam logic [6:0] T_I  = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111;
   localparam logic [6:0] T_JALR = 7'b1100111, T_BAD = 7'b1111111;
   localparam logic [6:0] F7_M = 7'b0000001, F7_ALT = 7'b0100000;

   typedef struct packed {
      logic rw, mw, j, b, jr, as, op5;
      logic [1:0] rs, st;
      logic [2:0] ld;
      logic [3:0] alu;
      logic mdv;
      logic [2:0] mdop;
      logic ill;
   } e_t;

   logic clk, reset_n, ValidD, StallE, FlushE;
   logic [6:0] op, funct7;
   logic [2:0] funct3;
   logic [1:0] ImmSrcD, ResultSrcE, StoreE;
   logic MdStallD, RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, Op5E;
   logic [2:0] LoadE, MdOpE;
   logic [3:0] ALUControlE;
   logic MdValidE, MdStartE, IllegalE;

   logic [1:0] nm_ImmSrcD, nm_ResultSrcE, nm_StoreE;
   logic nm_MdStallD, nm_RegWriteE, nm_MemWriteE, nm_JumpE, nm_BranchE, nm_JalrE;
   logic nm_ALUSrcE, nm_Op5E, nm_MdValidE, nm_MdStartE, nm_IllegalE;
   logic [2:0] nm_LoadE, nm_MdOpE;
   logic [3:0] nm_ALUControlE;

   int checks = 0;
   int errors = 0;

   e_t dut_e;
   e_t m_e;
   logic m_start;
   int m_busy;
   logic chk_en = 1'b0;

   pipe_controller #(.ENABLE_M(1'b1), .MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7(funct7),
      .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE), .ImmSrcD(ImmSrcD),
      .MdStallD(MdStallD), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
      .BranchE(BranchE), .JalrE(JalrE), .ALUSrcE(ALUSrcE), .Op5E(Op5E),
      .ResultSrcE(ResultSrcE), .StoreE(StoreE), .LoadE(LoadE), .ALUControlE(ALUControlE),
      .MdValidE(MdValidE), .MdOpE(MdOpE), .MdStartE(MdStartE), .IllegalE(IllegalE));

   pipe_controller #(.ENABLE_M(1'b0), .MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut_nm (
      .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7(funct7),
      .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE), .ImmSrcD(nm_ImmSrcD),
      .MdStallD(nm_MdStallD), .RegWriteE(nm_RegWriteE), .MemWriteE(nm_MemWriteE),
      .JumpE(nm_JumpE), .BranchE(nm_BranchE), .JalrE(nm_JalrE), .ALUSrcE(nm_ALUSrcE),
      .Op5E(nm_Op5E), .ResultSrcE(nm_ResultSrcE), .StoreE(nm_StoreE), .LoadE(nm_LoadE),
      .ALUControlE(nm_ALUControlE), .MdValidE(nm_MdValidE), .MdOpE(nm_MdOpE),
      .MdStartE(nm_MdStartE), .IllegalE(nm_IllegalE));

   assign dut_e = {RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, Op5E, ResultSrcE,
                   StoreE, LoadE, ALUControlE, MdValidE, MdOpE, IllegalE};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ALU codes: ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLL6 SRL7 SRA8 SLTU9
   function automatic logic [3:0] spec_alu(input logic [2:0] f3, input logic b30, input logic is_r);
      case (f3)
         3'd0: return (is_r && b30) ? 4'd1 : 4'd0;
         3'd1: return 4'd6;
         3'd2: return 4'd5;
         3'd3: return 4'd9;
         3'd4: return 4'd4;
         3'd5: return b30 ? 4'd8 : 4'd7;
         3'd6: return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   function automatic e_t spec_dec(input logic [6:0] o, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic v);
      e_t e = '0;
      if (!v) return e;
      e.op5 = o[5];
      case (o)
         T_LD:   begin e.rw = 1; e.as = 1; e.rs = 2'b01; e.ld = f3; end
         T_ST:   begin e.mw = 1; e.as = 1; e.st = f3[1:0]; end
         T_R:    if (f7 == F7_M) begin e.rw = 1; e.rs = 2'b11; e.mdv = 1; e.mdop = f3; end
                 else begin e.rw = 1; e.alu = spec_alu(f3, f7[5], 1'b1); end
         T_I:    begin e.rw = 1; e.as = 1; e.alu = spec_alu(f3, f7[5], 1'b0); end
         T_BR:   begin e.b = 1; e.alu = 4'd1; end
         T_JAL:  begin e.rw = 1; e.j = 1; e.rs = 2'b10; end
         T_JALR: begin e.rw = 1; e.jr = 1; e.as = 1; e.rs = 2'b10; end
         default: begin e = '0; e.ill = 1; end
      endcase
      return e;
   endfunction

   function automatic logic [1:0] spec_imm(input logic [6:0] o);
      case (o)
         T_ST:    return 2'b01;
         T_BR:    return 2'b10;
         T_JAL:   return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   // Model: Execute contents plus number of further cycles the M op keeps Decode frozen
   always @(posedge clk) begin
      if (!reset_n) begin
         m_e <= '0; m_start <= 1'b0; m_busy <= 0; chk_en <= 1'b1;
      end else if (m_busy > 0) begin
         m_busy <= m_busy - 1; m_start <= 1'b0;
      end else if (FlushE) begin
         m_e <= '0; m_start <= 1'b0;
      end else if (StallE) begin
         m_start <= 1'b0;
      end else begin
         m_e     <= spec_dec(op, funct3, funct7, ValidD);
         m_start <= spec_dec(op, funct3, funct7, ValidD).mdv;
         m_busy  <= spec_dec(op, funct3, funct7, ValidD).mdv ?
                    ((funct3[2] ? DIV_L : MUL_L) - 1) : 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("e_bundle", dut_e, m_e);
         chk("md_start", MdStartE, m_start);
         chk("md_stall", MdStallD, m_busy != 0);
         chk("imm_src", ImmSrcD, spec_imm(op));
         chk("flush_while_busy", FlushE && MdStallD, 1'b0);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7, input logic v);
      op = o; funct3 = f3; funct7 = f7; ValidD = v;
   endtask

   task automatic vec(input string name, input logic [6:0] o, input logic [2:0] f3,
                      input logic [6:0] f7, input logic v, input logic [3:0] alu);
      drive(o, f3, f7, v);
      cyc();
      chk(name, ALUControlE, alu);
   endtask

   // Issues an M op, then counts MdStallD cycles; StallE pulsed on cycles [s0,s1)
   task automatic run_md(input logic [2:0] f3, input int s0, input int s1, output int n);
      drive(T_R, f3, F7_M, 1'b1);
      cyc();
      chk("md_first_start", MdStartE, 1'b1);
      drive(T_R, 3'b000, 7'b0, 1'b1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!MdStallD) break;
         StallE = (i >= s0 && i < s1);
         n++;
         cyc();
      end
      StallE = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset_n = 1'b0; FlushE = 1'b0; StallE = 1'b0;
      drive(7'b0, 3'b0, 7'b0, 1'b0);
      cyc(); cyc();
      chk("rst_bundle", dut_e, '0);
      chk("rst_stall", MdStallD, 1'b0);
      chk("rst_start", MdStartE, 1'b0);
      reset_n = 1'b1;

      drive(T_R, 3'b000, 7'b0, 1'b1);
      cyc();
      chk("add_regwrite", RegWriteE, 1'b1);
      chk("add_alusrc", ALUSrcE, 1'b0);
      chk("add_aluctl", ALUControlE, 4'd0);
      chk("add_mdvalid", MdValidE, 1'b0);
      chk("nm_add_regwrite", nm_RegWriteE, 1'b1);

      vec("sub_alu",  T_R,   3'b000, F7_ALT, 1'b1, 4'd1);
      vec("slt_alu",  T_R,   3'b010, 7'b0,   1'b1, 4'd5);
      vec("sra_alu",  T_R,   3'b101, F7_ALT, 1'b1, 4'd8);
      vec("sltu_alu", T_R,   3'b011, 7'b0,   1'b1, 4'd9);
      vec("addi_alu", T_I,   3'b000, F7_ALT, 1'b1, 4'd0);
      vec("srai_alu", T_I,   3'b101, F7_ALT, 1'b1, 4'd8);
      vec("ori_alu",  T_I,   3'b110, 7'b0,   1'b1, 4'd3);
      vec("lw_alu",   T_LD,  3'b010, 7'b0,   1'b1, 4'd0);
      chk("lw_load", LoadE, 3'b010);
      chk("lw_result", ResultSrcE, 2'b01);
      vec("lbu_alu",  T_LD,  3'b100, 7'b0,   1'b1, 4'd0);
      vec("sb_alu",   T_ST,  3'b000, 7'b0,   1'b1, 4'd0);
      vec("sw_alu",   T_ST,  3'b010, 7'b0,   1'b1, 4'd0);
      chk("sw_store", StoreE, 2'b10);
      vec("beq_alu",  T_BR,  3'b000, 7'b0,   1'b1, 4'd1);
      vec("jal_alu",  T_JAL, 3'b000, 7'b0,   1'b1, 4'd0);
      chk("jal_jump", JumpE, 1'b1);
      vec("jalr_alu", T_JALR, 3'b000, 7'b0,  1'b1, 4'd0);
      chk("jalr_jalr", JalrE, 1'b1);
      vec("invalid_alu", T_R, 3'b000, F7_ALT, 1'b0, 4'd0);
      chk("invalid_regwrite", RegWriteE, 1'b0);

      run_md(3'b100, 99, 99, n);
      chk("div_stall_cycles", n, 33);
      cyc();
      chk("after_div_regwrite", RegWriteE, 1'b1);
      chk("after_div_mdvalid", MdValidE, 1'b0);
      run_md(3'b111, 5, 9, n);
      chk("remu_stall_cycles", n, 33);
      cyc();

      drive(T_R, 3'b000, F7_M, 1'b1);
      cyc();
      chk("mul_start", MdStartE, 1'b1);
      chk("mul_nostall", MdStallD, 1'b0);
      chk("nm_mul_illegal", nm_IllegalE, 1'b1);
      chk("nm_mul_regwrite", nm_RegWriteE, 1'b0);
      chk("nm_mul_memwrite", nm_MemWriteE, 1'b0);
      chk("nm_mul_mdvalid", nm_MdValidE, 1'b0);
      drive(T_R, 3'b011, F7_M, 1'b1);
      cyc();
      chk("mulhu_start", MdStartE, 1'b1);
      chk("mulhu_op", MdOpE, 3'b011);
      chk("mulhu_nostall", MdStallD, 1'b0);
      drive(T_R, 3'b000, 7'b0, 1'b1);
      cyc();
      chk("add_after_mul_start", MdStartE, 1'b0);

      drive(T_LD, 3'b010, 7'b0, 1'b1);
      FlushE = 1'b1; StallE = 1'b1;
      cyc();
      chk("flush_stall_bundle", dut_e, '0);
      FlushE = 1'b0; StallE = 1'b0;
      drive(T_ST, 3'b010, 7'b0, 1'b1);
      cyc();
      chk("sw_memwrite", MemWriteE, 1'b1);
      StallE = 1'b1;
      drive(T_R, 3'b000, 7'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("sw_stall_hold", MemWriteE, 1'b1);
      end
      StallE = 1'b0;
      cyc();
      chk("sw_release", MemWriteE, 1'b0);

      drive(T_BAD, 3'b000, 7'b0, 1'b1);
      cyc();
      chk("bad_illegal", IllegalE, 1'b1);
      chk("bad_regwrite", RegWriteE, 1'b0);
      chk("bad_memwrite", MemWriteE, 1'b0);

      drive(T_R, 3'b100, F7_M, 1'b1);
      cyc();
      drive(T_R, 3'b000, 7'b0, 1'b1);
      repeat (9) cyc();
      chk("div_mid_stall", MdStallD, 1'b1);
      reset_n = 1'b0;
      cyc();
      chk("rst_mid_stall", MdStallD, 1'b0);
      chk("rst_mid_bundle", dut_e, '0);
      chk("rst_mid_start", MdStartE, 1'b0);
      reset_n = 1'b1;
      cyc();
      chk("post_rst_regwrite", RegWriteE, 1'b1);
      chk("post_rst_alu", ALUControlE, 4'd0);
      chk("post_rst_mdvalid", MdValidE, 1'b0);
      cyc(); cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
